// File: rtl/v7_pulse_ctrl.sv
// v7_pulse_ctrl
//   Sequencing and capture controller for the v7 trapezoidal shaping filter.
//   After reset it pulses filt_clr and waits for the filter to settle. It then watches the
//   shaped output for upward threshold crossings and samples the flat-top amplitude at a
//   fixed offset from the crossing. Each accepted pulse goes downstream as one event
//   (amplitude + timestamp) over a valid/ready handshake. A pulse that falls back to the
//   threshold before capture is rejected as pile-up. Crossings that arrive while an event
//   is waiting or during holdoff are counted as lost.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   enable      1 = allow new pulses to start (gates IDLE -> RISE only)
//   threshold   signed trigger threshold
//   filt_data   signed shaped filter output
//   filt_clr    1 = clear filter state (held for CLR_CYC cycles after reset)
//   evt_valid   event available
//   evt_ready   downstream accepts the event
//   evt_amp     signed flat-top amplitude of the event
//   evt_ts      timestamp of the threshold crossing
//   pileup_cnt  pulses rejected as pile-up, saturating
//   lost_cnt    crossings missed while busy, saturating
//   busy        1 in any state other than IDLE
module v7_pulse_ctrl #(
  parameter int DATA_W     = 24,
  parameter int K_LEN      = 4,
  parameter int L_LEN      = 8,
  parameter int CLR_CYC    = 4,
  parameter int SETTLE_CYC = 16,
  parameter int HOLDOFF    = 8,
  parameter int TS_W       = 32,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic signed [DATA_W-1:0] filt_data,
  output logic                     filt_clr,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic signed [DATA_W-1:0] evt_amp,
  output logic        [TS_W-1:0]   evt_ts,
  output logic        [CNT_W-1:0]  pileup_cnt,
  output logic        [CNT_W-1:0]  lost_cnt,
  output logic                     busy
);

  // One shared sequence counter serves settle, rise/flat and holdoff timing, so it must
  // be wide enough for the longest of the three intervals.
  localparam int SETTLE_LEN = CLR_CYC + SETTLE_CYC;
  localparam int CAPT_LEN   = K_LEN + L_LEN / 2;
  localparam int SEQ_MAX_A  = (SETTLE_LEN > CAPT_LEN) ? SETTLE_LEN : CAPT_LEN;
  localparam int SEQ_MAX    = (SEQ_MAX_A > HOLDOFF) ? SEQ_MAX_A : HOLDOFF;
  localparam int SEQ_W      = $clog2(SEQ_MAX + 1);

  localparam logic [SEQ_W-1:0] CLR_END    = SEQ_W'(CLR_CYC);
  localparam logic [SEQ_W-1:0] SETTLE_END = SEQ_W'(SETTLE_LEN);
  localparam logic [SEQ_W-1:0] RISE_END   = SEQ_W'(K_LEN);
  localparam logic [SEQ_W-1:0] CAPT_AT    = SEQ_W'(CAPT_LEN);
  // Holdoff counts from 0 on entry, so reaching HOLDOFF-1 means HOLDOFF cycles spent.
  localparam logic [SEQ_W-1:0] HOLD_END   = SEQ_W'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_IDLE,
    ST_RISE,
    ST_FLAT,
    ST_OUT,
    ST_HOLD
  } state_t;

  state_t                     state_reg;
  logic        [SEQ_W-1:0]    seq_cnt_reg;
  logic        [TS_W-1:0]     ts_reg;
  logic signed [DATA_W-1:0]   prev_reg;

  logic             above;
  logic             prev_above;
  logic             crossing;
  logic [SEQ_W-1:0] seq_inc;

  // Signed compare on both the current and the previous sample; a crossing is an
  // upward transition through the threshold.
  assign above      = filt_data > threshold;
  assign prev_above = prev_reg > threshold;
  assign crossing   = above && !prev_above;
  assign seq_inc    = seq_cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_SETTLE;
      seq_cnt_reg <= '0;
      ts_reg      <= '0;
      prev_reg    <= '0;
      filt_clr    <= 1'b1;
      evt_valid   <= 1'b0;
      evt_amp     <= '0;
      evt_ts      <= '0;
      pileup_cnt  <= '0;
      lost_cnt    <= '0;
      busy        <= 1'b1;
    end else begin
      ts_reg   <= ts_reg + 1'b1;
      prev_reg <= filt_data;

      case (state_reg)
        ST_SETTLE: begin
          // Counter value after this edge equals cycles elapsed since reset release.
          seq_cnt_reg <= seq_inc;
          filt_clr    <= (seq_inc < CLR_END);
          if (seq_inc >= SETTLE_END) begin
            state_reg   <= ST_IDLE;
            seq_cnt_reg <= '0;
            busy        <= 1'b0;
          end
        end

        ST_IDLE: begin
          if (crossing && enable) begin
            state_reg   <= ST_RISE;
            evt_ts      <= ts_reg;
            seq_cnt_reg <= {{(SEQ_W-1){1'b0}}, 1'b1};
            busy        <= 1'b1;
          end
        end

        ST_RISE, ST_FLAT: begin
          if (!above) begin
            // Signal fell back before the flat-top sample: overlapping pulse.
            if (pileup_cnt != {CNT_W{1'b1}}) pileup_cnt <= pileup_cnt + 1'b1;
            state_reg   <= ST_HOLD;
            seq_cnt_reg <= '0;
          end else if (seq_cnt_reg == CAPT_AT) begin
            // Middle of the flat top.
            evt_amp   <= filt_data;
            evt_valid <= 1'b1;
            state_reg <= ST_OUT;
          end else begin
            seq_cnt_reg <= seq_inc;
            if (seq_inc >= RISE_END) state_reg <= ST_FLAT;
          end
        end

        ST_OUT: begin
          if (crossing && (lost_cnt != {CNT_W{1'b1}})) lost_cnt <= lost_cnt + 1'b1;
          if (evt_ready) begin
            evt_valid   <= 1'b0;
            state_reg   <= ST_HOLD;
            seq_cnt_reg <= '0;
          end
        end

        ST_HOLD: begin
          if (crossing && (lost_cnt != {CNT_W{1'b1}})) lost_cnt <= lost_cnt + 1'b1;
          if ((seq_cnt_reg >= HOLD_END) && !above) begin
            state_reg   <= ST_IDLE;
            seq_cnt_reg <= '0;
            busy        <= 1'b0;
          end else if (seq_cnt_reg < HOLD_END) begin
            // Counter parks at HOLD_END while the signal stays above threshold.
            seq_cnt_reg <= seq_inc;
          end
        end

        default: begin
          state_reg <= ST_SETTLE;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule
